bcd_display_scanner: RTL and testbench
======================================

Name: bcd_display_scanner

Overview:
- Reads the eight stored 4-bit BCD digits from the keypad-lock shift-register array and drives a time-multiplexed 8-digit 7-segment display.
- Decodes BCD to segments, blanks unentered positions, and masks digits as '-' in password-set mode.
- Marks the most recently entered digit with the decimal point.
- Sits downstream of the UI and SP shift-register arrays; a mux outside this block selects which array feeds it.

Parameters:
- NUM_DIGITS, 8, number of display positions; also the width of an_out. digits_in is 4*NUM_DIGITS bits.
- PRESCALE, 4, clock cycles each digit slot is held. Legal range is 1..65535.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  scan enable. Low freezes the scan and blanks the display.
- digits_in  input  32  digit1 in [31:28] through digit8 in [3:0]. Same ordering as the comparator concatenation.
- digit_count  input  4  number of digits entered, 0..8. Values above 8 saturate to 8.
- mask_en  input  1  when 1, every entered digit displays as '-'.
- seg_out  output  7  active-high segments, bit order {g,f,e,d,c,b,a}.
- an_out  output  8  one-hot active-high digit select; an_out[k] selects slot k, which shows digit k+1.
- dp_out  output  1  decimal point, active-high.
- frame_done  output  1  one-cycle pulse when a full 8-slot frame completes.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Prescaler = 0; scan index = 0; shadow registers = 0.
  - seg_out = 0, an_out = 0, dp_out = 0, frame_done = 0.
- Prescaler: counts 0..PRESCALE-1 while enable=1. The terminal count advances the slot. PRESCALE=1 advances the slot every cycle.
- Slot timing:
  - First rising edge with enable=1 after reset (or after enable rises): enter slot 0.
  - Each slot is held exactly PRESCALE cycles. Slot index wraps 7->0.
  - All outputs are registered and change only on the slot-entry edge.
- Frame snapshot: on every entry to slot 0, digits_in, saturated digit_count and mask_en are captured into shadow registers. The whole frame uses only the shadow values, so mid-frame input changes do not appear until the next frame.
- Per-slot content for slot k, with d = shadow digit k+1 and n = shadow count:
  - k >= n: seg_out = 0000000 (blank). an_out is still driven.
  - else if mask = 1: seg_out = 1000000 ('-').
  - else if d <= 9: standard pattern, listed below.
  - else (d = 10..15): seg_out = 1111001 ('E').
  - dp_out = 1 only when n > 0 and k == n-1, including in masked mode.
- BCD patterns {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- frame_done: 1 for exactly the cycle after the edge that enters slot 0 from slot 7. It does not fire on the first slot 0 after reset or after enable rises.
- enable=0:
  - On the next edge: an_out = 0, seg_out = 0, dp_out = 0, frame_done = 0.
  - Prescaler and scan index reset to 0.
  - Re-enable restarts at slot 0 with a fresh snapshot.
- Reset mid-frame: immediate return to the reset state; no partial frame_done.

Decomposition:
- Shared package holds:
  - NUM_DIGITS.
  - Segment constants SEG_BLANK, SEG_DASH, SEG_ERR.
  - The 10-entry BCD segment table.
- One combinational sub-module, bcd_to_seg7: 4-bit BCD in, 7-bit pattern out, 'E' for 10..15.
- Prescaler, scan index, shadow registers and output registers stay in the top module.

Test Plan:
- Reset then enable=1, PRESCALE=2, digits_in=0x21935488, digit_count=8, mask_en=0 -> an_out steps 01,02,04,...,80, each held 2 cycles. seg_out = 1011011, 0000110, 1101111, 1001111, 1101101, 1100110, 1111111, 1111111. dp only on slot 7. frame_done pulses once per 16 cycles after the first frame.
- digit_count=3, same digits -> slots 0..2 show 2,1,9 with dp on slot 2; slots 3..7 have seg_out=0 while an_out is still one-hot.
- mask_en=1, digit_count=5 -> slots 0..4 seg_out=1000000 with dp on slot 4; slots 5..7 blank.
- Change digits_in from 0x21935488 to 0x21935477 during slot 3 -> the current frame still shows 8,8 in slots 6..7; the next frame shows 7,7.
- digits_in=0xA0000000, digit_count=9 -> slot 0 shows 1111001 ('E'), count saturates to 8, dp on slot 7.
- Deassert enable mid-slot 4, then assert rst_n=0 asynchronously between clock edges -> outputs are 0 the next cycle after enable drops, and 0 immediately on reset. After release, the first an_out is 01 with no frame_done.

Source files
------------

// File: rtl/bcd_display_scanner_pkg.sv
// rtl/bcd_display_scanner_pkg.sv - shared constants and BCD segment table for the display scanner
package bcd_display_scanner_pkg;

    localparam int NUM_DIGITS = 8;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_ERR   = 7'b1111001;

    // Index n holds the pattern for BCD digit n
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

endpackage

// File: rtl/bcd_display_scanner_bcd_to_seg7.sv
// rtl/bcd_display_scanner_bcd_to_seg7.sv - combinational BCD to 7-segment decoder, 'E' for 10..15
module bcd_to_seg7
    import bcd_display_scanner_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Table lookup for legal digits, error glyph for anything above 9
    always_comb begin
        seg_o = SEG_ERR;
        if (bcd_i <= 4'd9) begin
            seg_o = SEG_TABLE[bcd_i];
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - time-multiplexed 8-digit 7-segment scanner for the keypad-lock digits
module bcd_display_scanner #(
    parameter int NUM_DIGITS = bcd_display_scanner_pkg::NUM_DIGITS,
    parameter int PRESCALE   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [3:0]              digit_count,
    input  logic                    mask_en,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    dp_out,
    output logic                    frame_done
);
    import bcd_display_scanner_pkg::*;

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    active_q, active_d;
    logic [15:0]             presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] dig_q;
    logic [3:0]              cnt_q;
    logic                    mask_q;
    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    dp_q;
    logic                    fd_q;

    logic                    enter;
    logic                    wrap;
    logic                    snap;
    logic [3:0]              cnt_sat;
    logic [4*NUM_DIGITS-1:0] src_digits;
    logic [3:0]              src_cnt;
    logic                    src_mask;
    logic [3:0]              sel_digit;
    logic [6:0]              dec_seg;
    logic [6:0]              seg_d;
    logic                    dp_d;

    // Prescaler and slot sequencing; enter marks an edge that starts a new slot
    always_comb begin
        active_d = active_q;
        presc_d  = presc_q;
        idx_d    = idx_q;
        enter    = 1'b0;
        wrap     = 1'b0;
        if (!enable) begin
            active_d = 1'b0;
            presc_d  = '0;
            idx_d    = '0;
        end else if (!active_q) begin
            active_d = 1'b1;
            presc_d  = '0;
            idx_d    = '0;
            enter    = 1'b1;
        end else if (presc_q == 16'(PRESCALE - 1)) begin
            presc_d = '0;
            enter   = 1'b1;
            if (idx_q == IW'(NUM_DIGITS - 1)) begin
                idx_d = '0;
                wrap  = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

    // Slot 0 is rendered from the live inputs since the shadows load on that same edge
    assign cnt_sat    = (digit_count > 4'(NUM_DIGITS)) ? 4'(NUM_DIGITS) : digit_count;
    assign snap       = enter && (idx_d == '0);
    assign src_digits = snap ? digits_in : dig_q;
    assign src_cnt    = snap ? cnt_sat : cnt_q;
    assign src_mask   = snap ? mask_en : mask_q;
    assign sel_digit  = 4'(src_digits >> (4 * (NUM_DIGITS - 1 - int'(idx_d))));

    bcd_to_seg7 u_dec (
        .bcd_i (sel_digit),
        .seg_o (dec_seg)
    );

    // Per-slot glyph selection: blank beyond the entered count, dash when masked
    always_comb begin
        seg_d = dec_seg;
        dp_d  = (int'(src_cnt) == int'(idx_d) + 1);
        if (int'(idx_d) >= int'(src_cnt)) begin
            seg_d = SEG_BLANK;
        end else if (src_mask) begin
            seg_d = SEG_DASH;
        end
    end

    // Scan state, frame shadows and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            presc_q  <= '0;
            idx_q    <= '0;
            dig_q    <= '0;
            cnt_q    <= '0;
            mask_q   <= 1'b0;
            seg_q    <= '0;
            an_q     <= '0;
            dp_q     <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            active_q <= active_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            fd_q     <= 1'b0;
            if (snap) begin
                dig_q  <= digits_in;
                cnt_q  <= cnt_sat;
                mask_q <= mask_en;
            end
            if (!enable) begin
                seg_q <= '0;
                an_q  <= '0;
                dp_q  <= 1'b0;
            end else if (enter) begin
                seg_q <= seg_d;
                an_q  <= NUM_DIGITS'(1) << idx_d;
                dp_q  <= dp_d;
                fd_q  <= wrap;
            end
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign dp_out     = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - directed self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] digits_in;
    logic [3:0]  digit_count;
    logic        mask_en;
    logic [6:0]  seg_out;
    logic [7:0]  an_out;
    logic        dp_out;
    logic        frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S7 = 7'b0000111;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1101111;
    localparam logic [6:0] SD = 7'b1000000;
    localparam logic [6:0] SE = 7'b1111001;
    localparam logic [6:0] SB = 7'b0000000;

    bcd_display_scanner #(
        .NUM_DIGITS (8),
        .PRESCALE   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .digits_in   (digits_in),
        .digit_count (digit_count),
        .mask_en     (mask_en),
        .seg_out     (seg_out),
        .an_out      (an_out),
        .dp_out      (dp_out),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".an"}, 32'(an_out), 32'h0);
        chk({tag, ".seg"}, 32'(seg_out), 32'h0);
        chk({tag, ".dp"}, 32'(dp_out), 32'h0);
        chk({tag, ".fd"}, 32'(frame_done), 32'h0);
    endtask

    // Called at the negedge right after a slot-entry edge; leaves at the next slot's first negedge
    task automatic check_slot(input string tag, input logic [7:0] an, input logic [6:0] seg,
                              input logic dp, input logic fd);
        chk({tag, ".an"}, 32'(an_out), 32'(an));
        chk({tag, ".seg"}, 32'(seg_out), 32'(seg));
        chk({tag, ".dp"}, 32'(dp_out), 32'(dp));
        chk({tag, ".fd"}, 32'(frame_done), 32'(fd));
        @(negedge clk);
        chk({tag, ".an_hold"}, 32'(an_out), 32'(an));
        chk({tag, ".seg_hold"}, 32'(seg_out), 32'(seg));
        chk({tag, ".fd_hold"}, 32'(frame_done), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        digits_in   = 32'h21935488;
        digit_count = 4'd8;
        mask_en     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        // Frame A: full count, input change mid-frame must not show
        check_slot("A0", 8'h01, S2, 1'b0, 1'b0);
        check_slot("A1", 8'h02, S1, 1'b0, 1'b0);
        check_slot("A2", 8'h04, S9, 1'b0, 1'b0);
        digits_in = 32'h21935477;
        check_slot("A3", 8'h08, S3, 1'b0, 1'b0);
        check_slot("A4", 8'h10, S5, 1'b0, 1'b0);
        check_slot("A5", 8'h20, S4, 1'b0, 1'b0);
        check_slot("A6", 8'h40, S8, 1'b0, 1'b0);
        check_slot("A7", 8'h80, S8, 1'b1, 1'b0);

        // Frame B: new digits appear, count change mid-frame ignored
        check_slot("B0", 8'h01, S2, 1'b0, 1'b1);
        digit_count = 4'd3;
        check_slot("B1", 8'h02, S1, 1'b0, 1'b0);
        check_slot("B2", 8'h04, S9, 1'b0, 1'b0);
        check_slot("B3", 8'h08, S3, 1'b0, 1'b0);
        check_slot("B4", 8'h10, S5, 1'b0, 1'b0);
        check_slot("B5", 8'h20, S4, 1'b0, 1'b0);
        check_slot("B6", 8'h40, S7, 1'b0, 1'b0);
        check_slot("B7", 8'h80, S7, 1'b1, 1'b0);

        // Frame C: three digits entered
        check_slot("C0", 8'h01, S2, 1'b0, 1'b1);
        mask_en     = 1'b1;
        digit_count = 4'd5;
        check_slot("C1", 8'h02, S1, 1'b0, 1'b0);
        check_slot("C2", 8'h04, S9, 1'b1, 1'b0);
        check_slot("C3", 8'h08, SB, 1'b0, 1'b0);
        check_slot("C4", 8'h10, SB, 1'b0, 1'b0);
        check_slot("C5", 8'h20, SB, 1'b0, 1'b0);
        check_slot("C6", 8'h40, SB, 1'b0, 1'b0);
        check_slot("C7", 8'h80, SB, 1'b0, 1'b0);

        // Frame D: masked, five digits
        check_slot("D0", 8'h01, SD, 1'b0, 1'b1);
        digits_in   = 32'hA0000000;
        digit_count = 4'd9;
        mask_en     = 1'b0;
        check_slot("D1", 8'h02, SD, 1'b0, 1'b0);
        check_slot("D2", 8'h04, SD, 1'b0, 1'b0);
        check_slot("D3", 8'h08, SD, 1'b0, 1'b0);
        check_slot("D4", 8'h10, SD, 1'b1, 1'b0);
        check_slot("D5", 8'h20, SB, 1'b0, 1'b0);
        check_slot("D6", 8'h40, SB, 1'b0, 1'b0);
        check_slot("D7", 8'h80, SB, 1'b0, 1'b0);

        // Frame E: error glyph, saturated count, then enable drops in slot 4
        check_slot("E0", 8'h01, SE, 1'b0, 1'b1);
        check_slot("E1", 8'h02, S0, 1'b0, 1'b0);
        check_slot("E2", 8'h04, S0, 1'b0, 1'b0);
        check_slot("E3", 8'h08, S0, 1'b0, 1'b0);
        chk("E4.an", 32'(an_out), 32'h10);
        chk("E4.seg", 32'(seg_out), 32'(S0));
        enable = 1'b0;
        @(negedge clk);
        chk_zero("dis1");
        @(negedge clk);
        chk_zero("dis2");

        // Re-enable restarts at slot 0 with a fresh snapshot
        digits_in   = 32'h21935488;
        digit_count = 4'd8;
        enable      = 1'b1;
        @(negedge clk);
        check_slot("F0", 8'h01, S2, 1'b0, 1'b0);
        chk("F1.an", 32'(an_out), 32'h02);
        chk("F1.seg", 32'(seg_out), 32'(S1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        chk_zero("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);

        // Frame G after reset: no frame_done until it wraps
        check_slot("G0", 8'h01, S2, 1'b0, 1'b0);
        check_slot("G1", 8'h02, S1, 1'b0, 1'b0);
        check_slot("G2", 8'h04, S9, 1'b0, 1'b0);
        check_slot("G3", 8'h08, S3, 1'b0, 1'b0);
        check_slot("G4", 8'h10, S5, 1'b0, 1'b0);
        check_slot("G5", 8'h20, S4, 1'b0, 1'b0);
        check_slot("G6", 8'h40, S8, 1'b0, 1'b0);
        check_slot("G7", 8'h80, S8, 1'b1, 1'b0);
        check_slot("H0", 8'h01, S2, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
